// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the seven-segment display driver.
//   - Active-low segment constants, bit order g..a (bit 6 = g).
//   - Conversion FSM state encoding.
//   - max_display_value(n): largest value that fits on n decimal digits (10^n - 1).
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  function automatic logic [63:0] max_display_value(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode
//   Combinational BCD digit to active-low seven-segment decoder.
//   Codes 10..15 cannot come out of the conversion engine; they decode to blank.
// Ports:
//   bcd  in  4  BCD digit
//   seg  out 7  active-low segments, bit 6 = g .. bit 0 = a
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_bcd_display.sv
// seg7_bcd_display
//   Binary to multi-digit seven-segment display driver. A WIDTH-bit unsigned
//   value is converted to DIGITS BCD digits with a shift-and-add-3 engine
//   (one bit per clock), then encoded and registered onto the segment pins.
//   Values above 10^DIGITS-1 show dashes on every digit and raise ovf.
//   Optional macro SEG7_LZ_BLANK_EN: blank leading zero digits (digit 0 is
//   always shown; the all-dash overflow display is unaffected).
// Ports:
//   clk    in   1          system clock, rising edge
//   rst    in   1          synchronous active-high reset
//   load   in   1          start a conversion of value (honoured only in IDLE)
//   value  in   WIDTH      unsigned binary value
//   busy   out  1          conversion in progress
//   done   out  1          one-cycle pulse after seg/ovf update
//   ovf    out  1          last value did not fit the display
//   seg    out  7*DIGITS   active-low segments, digit i at [7i+6:7i]
//
// state  | meaning
// IDLE   | waiting for load; done pulse is visible here
// SHIFT  | one add-3/shift step per cycle, WIDTH cycles
// UPDATE | encode BCD result, register seg/ovf, raise done
module seg7_bcd_display
  import seg7_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int          BW      = 4 * DIGITS;
  localparam int          CW      = $clog2(WIDTH + 1);
  localparam logic [63:0] MAX_VAL = max_display_value(DIGITS);

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q;
  logic [WIDTH-1:0]            shreg_q;
  logic [BW-1:0]               bcd_q;
  logic [BW-1:0]               bcd_adj;
  logic                        ovf_cap_q;
  logic [7*DIGITS-1:0]         seg_q;
  logic [7*DIGITS-1:0]         seg_upd;
  logic                        ovf_q;
  logic                        done_q;
  logic [DIGITS-1:0][6:0]      enc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        // cnt_q == 1 means this edge performs the last of WIDTH shifts
        if (cnt_q == CW'(1)) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encode u_enc (
      .bcd (bcd_q[4*g +: 4]),
      .seg (enc[g])
    );
  end

  always_comb begin
`ifdef SEG7_LZ_BLANK_EN
    logic leading;
    leading = 1'b1;
`endif
    seg_upd = enc;
    if (ovf_cap_q) begin
      seg_upd = {DIGITS{SEG_DASH}};
    end else begin
`ifdef SEG7_LZ_BLANK_EN
      // walk down from the top digit; blank zeros until the first non-zero
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (leading && (bcd_q[4*i +: 4] == 4'd0)) begin
          seg_upd[7*i +: 7] = SEG_BLANK;
        end else begin
          leading = 1'b0;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      shreg_q   <= '0;
      bcd_q     <= '0;
      ovf_cap_q <= 1'b0;
      seg_q     <= {DIGITS{SEG_BLANK}};
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            shreg_q   <= value;
            bcd_q     <= '0;
            ovf_cap_q <= (64'(value) > MAX_VAL);
            cnt_q     <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          // bits leaving the top of the BCD register only matter on overflow,
          // where the result is replaced by dashes anyway
          bcd_q   <= {bcd_adj[BW-2:0], shreg_q[WIDTH-1]};
          shreg_q <= shreg_q << 1;
          cnt_q   <= cnt_q - CW'(1);
        end
        UPDATE: begin
          seg_q  <= seg_upd;
          ovf_q  <= ovf_cap_q;
          done_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign seg  = seg_q;
  assign ovf  = ovf_q;
  assign done = done_q;

endmodule

// File: tb/tb_seg7_bcd_display.sv
module tb_seg7_bcd_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] LZ0 = SB;
`else
  localparam logic [6:0] LZ0 = S0;
`endif

  logic        clk;
  logic        rst;
  logic        load3, load2;
  logic [7:0]  value3, value2;
  logic        busy3, busy2, done3, done2, ovf3, ovf2;
  logic [20:0] seg3;
  logic [13:0] seg2;

  int errors;
  int checks;
  int n;
  int dcnt;

  seg7_bcd_display #(.WIDTH(8), .DIGITS(3)) dut3 (
    .clk   (clk),
    .rst   (rst),
    .load  (load3),
    .value (value3),
    .busy  (busy3),
    .done  (done3),
    .ovf   (ovf3),
    .seg   (seg3)
  );

  seg7_bcd_display #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .load  (load2),
    .value (value2),
    .busy  (busy2),
    .done  (done2),
    .ovf   (ovf2),
    .seg   (seg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start3(input logic [7:0] v);
    value3 = v;
    load3  = 1'b1;
    tick();
    load3  = 1'b0;
    value3 = 8'h5A;
  endtask

  task automatic start2(input logic [7:0] v);
    value2 = v;
    load2  = 1'b1;
    tick();
    load2  = 1'b0;
    value2 = 8'hA5;
  endtask

  task automatic wait_done(input bit sel2, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (((sel2 ? done2 : done3) !== 1'b1) && cyc < 30);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    load3  = 1'b0;
    load2  = 1'b0;
    value3 = '0;
    value2 = '0;
    repeat (3) tick();

    check("rst_seg3", 64'(seg3), 64'({SB, SB, SB}));
    check("rst_seg2", 64'(seg2), 64'({SB, SB}));
    check("rst_busy3", 64'(busy3), 64'd0);
    check("rst_busy2", 64'(busy2), 64'd0);
    check("rst_done3", 64'(done3), 64'd0);
    check("rst_done2", 64'(done2), 64'd0);
    check("rst_ovf3", 64'(ovf3), 64'd0);
    check("rst_ovf2", 64'(ovf2), 64'd0);
    rst = 1'b0;
    tick();

    // 255 on three digits; value input changes right after acceptance
    start3(8'd255);
    check("v255_busy", 64'(busy3), 64'd1);
    wait_done(1'b0, n);
    check("v255_lat", 64'(n), 64'd9);
    check("v255_seg", 64'(seg3), 64'({S2, S5, S5}));
    check("v255_ovf", 64'(ovf3), 64'd0);
    check("v255_busy_end", 64'(busy3), 64'd0);
    tick();
    check("v255_done_pulse", 64'(done3), 64'd0);
    check("v255_seg_hold", 64'(seg3), 64'({S2, S5, S5}));

    start3(8'd0);
    wait_done(1'b0, n);
    check("v0_lat", 64'(n), 64'd9);
    check("v0_seg", 64'(seg3), 64'({LZ0, LZ0, S0}));

    start3(8'd100);
    wait_done(1'b0, n);
    check("v100_d3_seg", 64'(seg3), 64'({S1, S0, S0}));

    // overflow boundary on two digits
    start2(8'd100);
    wait_done(1'b1, n);
    check("ovf100_lat", 64'(n), 64'd9);
    check("ovf100_seg", 64'(seg2), 64'({SD, SD}));
    check("ovf100_ovf", 64'(ovf2), 64'd1);
    start2(8'd99);
    wait_done(1'b1, n);
    check("v99_seg", 64'(seg2), 64'({S9, S9}));
    check("v99_ovf", 64'(ovf2), 64'd0);
    start2(8'd255);
    wait_done(1'b1, n);
    check("ovf255_seg", 64'(seg2), 64'({SD, SD}));
    check("ovf255_ovf", 64'(ovf2), 64'd1);

    // load while busy is ignored
    start2(8'd42);
    tick();
    tick();
    value2 = 8'd7;
    load2  = 1'b1;
    tick();
    load2  = 1'b0;
    dcnt   = 0;
    repeat (15) begin
      tick();
      if (done2 === 1'b1) dcnt++;
    end
    check("busyload_dones", 64'(dcnt), 64'd1);
    check("busyload_seg", 64'(seg2), 64'({S4, S2}));
    check("busyload_ovf", 64'(ovf2), 64'd0);

    // reset in the middle of a conversion
    start3(8'd200);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy3), 64'd0);
    check("abort_done", 64'(done3), 64'd0);
    check("abort_seg3", 64'(seg3), 64'({SB, SB, SB}));
    check("abort_ovf3", 64'(ovf3), 64'd0);
    check("abort_seg2", 64'(seg2), 64'({SB, SB}));
    dcnt = 0;
    repeat (12) begin
      tick();
      if (done3 === 1'b1) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    start3(8'd5);
    wait_done(1'b0, n);
    check("v5_lat", 64'(n), 64'd9);
    check("v5_digit0", 64'(seg3[6:0]), 64'(S5));
    check("v5_seg", 64'(seg3), 64'({LZ0, LZ0, S5}));

    // back-to-back: second load in the done cycle
    start2(8'd1);
    wait_done(1'b1, n);
    check("b2b1_lat", 64'(n), 64'd9);
    check("b2b1_seg", 64'(seg2), 64'({LZ0, S1}));
    start2(8'd2);
    check("b2b2_accept", 64'(busy2), 64'd1);
    wait_done(1'b1, n);
    check("b2b2_lat", 64'(n), 64'd9);
    check("b2b2_digit0", 64'(seg2[6:0]), 64'(S2));
    check("b2b2_seg", 64'(seg2), 64'({LZ0, S2}));
    tick();
    check("b2b2_done_pulse", 64'(done2), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
